// File: rtl/fir_xifu_scoreboard.sv
// XIFU in-flight instruction scoreboard.
// Age-ordered circular FIFO of issued instructions. It detects RAW hazards on
// the offered instruction, tracks commit/kill per id, and retires the head.
module fir_xifu_scoreboard #(
   parameter int unsigned NB_REGS  = 4,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ID_WIDTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clear_i,
   input  logic                         issue_valid_i,
   output logic                         issue_ready_o,
   input  logic [ID_WIDTH-1:0]          issue_id_i,
   input  logic [$clog2(NB_REGS)-1:0]   issue_rd_i,
   input  logic                         issue_rd_we_i,
   input  logic [$clog2(NB_REGS)-1:0]   issue_rs1_i,
   input  logic [$clog2(NB_REGS)-1:0]   issue_rs2_i,
   input  logic                         issue_rs1_re_i,
   input  logic                         issue_rs2_re_i,
   output logic                         hazard_o,
   input  logic                         commit_valid_i,
   input  logic [ID_WIDTH-1:0]          commit_id_i,
   input  logic                         commit_kill_i,
   output logic                         head_valid_o,
   output logic [ID_WIDTH-1:0]          head_id_o,
   output logic                         head_committed_o,
   input  logic                         retire_i,
   output logic [$clog2(DEPTH):0]       count_o
);

   localparam int unsigned RW = $clog2(NB_REGS);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic                valid;
      logic [ID_WIDTH-1:0] id;
      logic [RW-1:0]       rd;
      logic                we;
      logic                committed;
      logic                killed;
   } entry_t;

   entry_t [DEPTH-1:0] ent_q, ent_d;
   logic   [PW-1:0]    head_q, head_d;
   logic   [PW-1:0]    tail_q, tail_d;
   logic   [CW-1:0]    count_q, count_d;

   entry_t head_ent;
   logic   raw_c;
   logic   full;
   logic   push;
   logic   pop;
   logic   push_commit;

   // RAW check: any live writer whose rd matches an enabled source
   always_comb begin
      raw_c = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid && !ent_q[i].killed && ent_q[i].we &&
             ((issue_rs1_re_i && (ent_q[i].rd == issue_rs1_i)) ||
              (issue_rs2_re_i && (ent_q[i].rd == issue_rs2_i)))) begin
            raw_c = 1'b1;
         end
      end
   end

   // Handshake, head view and push/pop decisions
   always_comb begin
      head_ent         = ent_q[head_q];
      full             = (count_q == CW'(DEPTH));
      hazard_o         = issue_valid_i && raw_c;
      issue_ready_o    = !full && !hazard_o;
      push             = issue_valid_i && issue_ready_o;
      head_valid_o     = head_ent.valid && !head_ent.killed;
      head_committed_o = head_valid_o && head_ent.committed;
      head_id_o        = head_ent.valid ? head_ent.id : '0;
      // A killed head drains on its own; a committed head waits for WB
      pop              = head_ent.valid && (head_ent.killed || (retire_i && head_committed_o));
      push_commit      = commit_valid_i && (commit_id_i == issue_id_i);
      count_o          = count_q;
   end

   // Next-state: flush, commit marking, push at tail, pop at head
   always_comb begin
      ent_d   = ent_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear_i) begin
         ent_d   = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (commit_valid_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (ent_q[i].valid && (ent_q[i].id == commit_id_i)) begin
                  ent_d[i].committed = 1'b1;
                  ent_d[i].killed    = commit_kill_i;
               end
            end
         end
         if (push) begin
            ent_d[tail_q].valid     = 1'b1;
            ent_d[tail_q].id        = issue_id_i;
            ent_d[tail_q].rd        = issue_rd_i;
            ent_d[tail_q].we        = issue_rd_we_i;
            ent_d[tail_q].committed = push_commit;
            ent_d[tail_q].killed    = push_commit && commit_kill_i;
            tail_d                  = tail_q + PW'(1);
         end
         if (pop) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = head_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ent_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         ent_q   <= ent_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_fir_xifu_scoreboard.sv
// Scoreboard bench for fir_xifu_scoreboard: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_fir_xifu_scoreboard;

   localparam int unsigned NB_REGS  = 4;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned ID_WIDTH = 4;

   logic                clk_i = 1'b0;
   logic                rst_ni;
   logic                clear_i;
   logic                issue_valid_i;
   logic                issue_ready_o;
   logic [ID_WIDTH-1:0] issue_id_i;
   logic [1:0]          issue_rd_i;
   logic                issue_rd_we_i;
   logic [1:0]          issue_rs1_i;
   logic [1:0]          issue_rs2_i;
   logic                issue_rs1_re_i;
   logic                issue_rs2_re_i;
   logic                hazard_o;
   logic                commit_valid_i;
   logic [ID_WIDTH-1:0] commit_id_i;
   logic                commit_kill_i;
   logic                head_valid_o;
   logic [ID_WIDTH-1:0] head_id_o;
   logic                head_committed_o;
   logic                retire_i;
   logic [2:0]          count_o;

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   fir_xifu_scoreboard #(.NB_REGS(NB_REGS), .DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_id_i(issue_id_i), .issue_rd_i(issue_rd_i), .issue_rd_we_i(issue_rd_we_i),
      .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
      .issue_rs1_re_i(issue_rs1_re_i), .issue_rs2_re_i(issue_rs2_re_i),
      .hazard_o(hazard_o), .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
      .commit_kill_i(commit_kill_i), .head_valid_o(head_valid_o), .head_id_o(head_id_o),
      .head_committed_o(head_committed_o), .retire_i(retire_i), .count_o(count_o)
   );

   typedef struct {
      logic [3:0] id;
      logic [1:0] rd;
      logic       we;
      logic       committed;
      logic       killed;
   } m_ent_t;

   typedef struct {
      logic       v;
      logic [3:0] id;
      logic [1:0] rd;
      logic       we;
      logic [1:0] rs1;
      logic [1:0] rs2;
      logic       re1;
      logic       re2;
      logic       cv;
      logic [3:0] cid;
      logic       ck;
      logic       ret;
      logic       clr;
   } stim_t;

   typedef struct {
      logic       ready;
      logic       hazard;
      logic       hv;
      logic       hc;
      logic [3:0] hid;
      logic [2:0] cnt;
   } exp_t;

   m_ent_t model[$];
   exp_t   exp_q[$];

   function automatic stim_t idle_s();
      stim_t s;
      s = '{v:1'b0, id:4'd0, rd:2'd0, we:1'b0, rs1:2'd0, rs2:2'd0, re1:1'b0, re2:1'b0,
            cv:1'b0, cid:4'd0, ck:1'b0, ret:1'b0, clr:1'b0};
      return s;
   endfunction

   function automatic stim_t push_s(input logic [3:0] id, input logic [1:0] rd, input logic we);
      stim_t s;
      s    = idle_s();
      s.v  = 1'b1;
      s.id = id;
      s.rd = rd;
      s.we = we;
      return s;
   endfunction

   // Expected outputs from the in-flight list as it stands before the edge
   function automatic exp_t model_out(input stim_t s);
      exp_t e;
      logic hz;
      hz = 1'b0;
      if (s.v) begin
         foreach (model[i]) begin
            if (!model[i].killed && model[i].we &&
                ((s.re1 && model[i].rd == s.rs1) || (s.re2 && model[i].rd == s.rs2)))
               hz = 1'b1;
         end
      end
      e.hazard = hz;
      e.ready  = (model.size() < DEPTH) && !hz;
      e.cnt    = 3'(model.size());
      if (model.size() > 0) begin
         e.hid = model[0].id;
         e.hv  = !model[0].killed;
         e.hc  = !model[0].killed && model[0].committed;
      end else begin
         e.hid = 4'd0;
         e.hv  = 1'b0;
         e.hc  = 1'b0;
      end
      return e;
   endfunction

   // Advance the in-flight list across one clock edge
   task automatic model_step(input stim_t s, input exp_t e);
      logic   do_pop;
      m_ent_t n;
      if (s.clr) begin
         model.delete();
      end else begin
         do_pop = (model.size() > 0) && (model[0].killed || (s.ret && e.hc));
         if (s.cv) begin
            foreach (model[i]) begin
               if (model[i].id == s.cid) begin
                  model[i].committed = 1'b1;
                  model[i].killed    = s.ck;
               end
            end
         end
         if (s.v && e.ready) begin
            n.id        = s.id;
            n.rd        = s.rd;
            n.we        = s.we;
            n.committed = s.cv && (s.cid == s.id);
            n.killed    = s.cv && (s.cid == s.id) && s.ck;
            model.push_back(n);
         end
         if (do_pop) void'(model.pop_front());
      end
   endtask

   task automatic drive(input stim_t s);
      issue_valid_i  = s.v;
      issue_id_i     = s.id;
      issue_rd_i     = s.rd;
      issue_rd_we_i  = s.we;
      issue_rs1_i    = s.rs1;
      issue_rs2_i    = s.rs2;
      issue_rs1_re_i = s.re1;
      issue_rs2_re_i = s.re2;
      commit_valid_i = s.cv;
      commit_id_i    = s.cid;
      commit_kill_i  = s.ck;
      retire_i       = s.ret;
      clear_i        = s.clr;
   endtask

   task automatic apply(input stim_t s);
      exp_t e;
      @(negedge clk_i);
      rst_ni = 1'b1;
      drive(s);
      e = model_out(s);
      exp_q.push_back(e);
      model_step(s, e);
   endtask

   task automatic do_reset(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(negedge clk_i);
         rst_ni = 1'b0;
         drive(idle_s());
         model.delete();
         e = '{ready:1'b1, hazard:1'b0, hv:1'b0, hc:1'b0, hid:4'd0, cnt:3'd0};
         exp_q.push_back(e);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops one expectation per cycle and samples mid-low-phase
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("issue_ready", 32'(issue_ready_o), 32'(e.ready));
            check("hazard", 32'(hazard_o), 32'(e.hazard));
            check("head_valid", 32'(head_valid_o), 32'(e.hv));
            check("head_committed", 32'(head_committed_o), 32'(e.hc));
            check("head_id", 32'(head_id_o), 32'(e.hid));
            check("count", 32'(count_o), 32'(e.cnt));
         end
      end
   end

   // Stimulus: directed scenarios then randomized traffic
   initial begin
      stim_t s;
      int    n;
      rst_ni = 1'b0;
      drive(idle_s());
      do_reset(2);

      // Fill to full, then commit and retire the head
      for (int i = 1; i <= 4; i++) apply(push_s(4'(i), 2'd0, 1'b0));
      apply(push_s(4'd6, 2'd1, 1'b0));
      s = idle_s(); s.cv = 1'b1; s.cid = 4'd1; apply(s);
      s = idle_s(); s.ret = 1'b1; apply(s);
      apply(idle_s());
      s = idle_s(); s.clr = 1'b1; apply(s);

      // RAW hazard, then kill removes it and the entry drains
      apply(push_s(4'd5, 2'd2, 1'b1));
      s = push_s(4'd6, 2'd0, 1'b0); s.rs1 = 2'd2; s.re1 = 1'b1; apply(s);
      s.cv = 1'b1; s.cid = 4'd5; s.ck = 1'b1; apply(s);
      apply(idle_s());
      apply(idle_s());

      // Push and commit of the same id in one cycle
      s = push_s(4'd7, 2'd3, 1'b1); s.cv = 1'b1; s.cid = 4'd7; apply(s);
      apply(idle_s());
      s = idle_s(); s.clr = 1'b1; apply(s);

      // Full with simultaneous retire: push still rejected
      for (int i = 1; i <= 4; i++) apply(push_s(4'(i), 2'd1, 1'b0));
      s = idle_s(); s.cv = 1'b1; s.cid = 4'd1; apply(s);
      s = push_s(4'd8, 2'd0, 1'b0); s.ret = 1'b1; apply(s);
      apply(idle_s());

      // Clear wins over push, commit and retire
      s = push_s(4'd9, 2'd0, 1'b0); s.clr = 1'b1; s.cv = 1'b1; s.cid = 4'd2; s.ret = 1'b1; apply(s);
      apply(idle_s());

      // Stray commit and retire on an uncommitted head
      apply(push_s(4'd3, 2'd0, 1'b0));
      s = idle_s(); s.cv = 1'b1; s.cid = 4'd9; apply(s);
      s = idle_s(); s.ret = 1'b1; apply(s);
      apply(idle_s());

      // Reset mid-operation, then a commit to the discarded id
      apply(push_s(4'd4, 2'd1, 1'b1));
      do_reset(1);
      s = idle_s(); s.cv = 1'b1; s.cid = 4'd3; apply(s);
      apply(idle_s());

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         s     = idle_s();
         s.v   = ($urandom_range(0, 9) < 6);
         s.id  = 4'($urandom_range(0, 7));
         s.rd  = 2'($urandom);
         s.we  = 1'($urandom);
         s.rs1 = 2'($urandom);
         s.rs2 = 2'($urandom);
         s.re1 = 1'($urandom);
         s.re2 = 1'($urandom);
         s.cv  = ($urandom_range(0, 2) == 0);
         n     = model.size();
         if (n > 0 && $urandom_range(0, 3) != 0) s.cid = model[$urandom_range(0, n - 1)].id;
         else s.cid = 4'($urandom);
         s.ck  = ($urandom_range(0, 3) == 0);
         s.ret = 1'($urandom);
         s.clr = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 499) == 0) do_reset(1);
         else apply(s);
      end

      apply(idle_s());
      apply(idle_s());
      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      #3;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
